// File: rtl/decode_stage.sv
// Instruction decode stage: register file with write-through, immediate extension,
// ID/EX output register with valid/ready, load-use bubble insertion and flush.
module decode_stage #(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            instruction,
    input  logic [DATA_W-1:0]      pc_plus4,
    input  logic                   flush,
    input  logic                   wb_en,
    input  logic [4:0]             wb_reg,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [5:0]             opcode,
    output logic [5:0]             funct,
    output logic [4:0]             shamt,
    output logic [4:0]             rs,
    output logic [4:0]             rt,
    output logic [4:0]             rd,
    output logic [DATA_W-1:0]      read_data1,
    output logic [DATA_W-1:0]      read_data2,
    output logic [DATA_W-1:0]      imm_ext,
    output logic [DATA_W-1:0]      pc_plus4_out,
    output logic                   mem_read,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [5:0] OP_LW = 6'h23;

    logic [DATA_W-1:0]      rf_q [NUM_REGS];
    logic                   vld_q, vld_d;
    logic [31:0]            instr_q, instr_d;
    logic [DATA_W-1:0]      rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc_q, pc_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0]        rs_in, rt_in;
    logic [5:0]        op_in;
    logic [DATA_W-1:0] rd1_in, rd2_in, imm_in;
    logic              hazard, accept, bubble;

    assign op_in = instruction[31:26];
    assign rs_in = instruction[25:21];
    assign rt_in = instruction[20:16];

    // Write-through: a same-cycle write-back is visible to the decoding instruction.
    always_comb begin
        rd1_in = '0;
        rd2_in = '0;
        if (rs_in != 5'd0)
            rd1_in = (wb_en && wb_reg == rs_in) ? wb_data : rf_q[rs_in];
        if (rt_in != 5'd0)
            rd2_in = (wb_en && wb_reg == rt_in) ? wb_data : rf_q[rt_in];
    end

    always_comb begin
        case (op_in)
            6'h0C, 6'h0D, 6'h0E: imm_in = DATA_W'(instruction[15:0]);
            6'h0F:               imm_in = DATA_W'({instruction[15:0], 16'h0000});
            default:             imm_in = DATA_W'($signed(instruction[15:0]));
        endcase
    end

    // Load in ID/EX whose destination is a source of the instruction now in decode.
    assign hazard = vld_q && mem_read && (rt != 5'd0) && (rs_in == rt || rt_in == rt);
    assign in_ready = !rst && (!vld_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;
    assign bubble   = hazard && out_ready && !flush;

    always_comb begin
        vld_d   = vld_q;
        instr_d = instr_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (accept) begin
            vld_d   = 1'b1;
            instr_d = instruction;
            rd1_d   = rd1_in;
            rd2_d   = rd2_in;
            imm_d   = imm_in;
            pc_d    = pc_plus4;
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
        if (bubble && !(&cnt_q))
            cnt_d = cnt_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            instr_q <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            vld_q   <= vld_d;
            instr_q <= instr_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else if (wb_en && wb_reg != 5'd0) begin
            rf_q[wb_reg] <= wb_data;
        end
    end

    assign out_valid    = vld_q;
    assign opcode       = instr_q[31:26];
    assign rs           = instr_q[25:21];
    assign rt           = instr_q[20:16];
    assign rd           = instr_q[15:11];
    assign shamt        = instr_q[10:6];
    assign funct        = instr_q[5:0];
    assign mem_read     = (instr_q[31:26] == OP_LW);
    assign read_data1   = rd1_q;
    assign read_data2   = rd2_q;
    assign imm_ext      = imm_q;
    assign pc_plus4_out = pc_q;
    assign stall_count  = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized bench for decode_stage against a transaction-level model.
module tb_decode_stage;
    localparam int DW = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, flush, wb_en, out_valid, out_ready, mem_read;
    logic [31:0]   instruction;
    logic [DW-1:0] pc_plus4, wb_data, read_data1, read_data2, imm_ext, pc_plus4_out;
    logic [4:0]    wb_reg, shamt, rs, rt, rd;
    logic [5:0]    opcode, funct;
    logic [CW-1:0] stall_count;

    decode_stage #(.DATA_W(DW), .NUM_REGS(32), .STALL_CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc_plus4(pc_plus4), .flush(flush),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .funct(funct),
        .shamt(shamt), .rs(rs), .rt(rt), .rd(rd), .read_data1(read_data1),
        .read_data2(read_data2), .imm_ext(imm_ext), .pc_plus4_out(pc_plus4_out),
        .mem_read(mem_read), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: architectural register array plus the contents of the ID/EX slot.
    logic [DW-1:0] m_regs [32];
    logic          m_vld;
    logic [31:0]   m_ins;
    logic [DW-1:0] m_rd1, m_rd2, m_imm, m_pc;
    int            m_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input logic [4:0] a);
        if (a == 0) return '0;
        if (wb_en && wb_reg == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic [DW-1:0] m_immf(input logic [31:0] ins);
        case (ins[31:26])
            6'h0C, 6'h0D, 6'h0E: return {16'h0, ins[15:0]};
            6'h0F:               return {ins[15:0], 16'h0};
            default:             return {{16{ins[15]}}, ins[15:0]};
        endcase
    endfunction

    function automatic logic m_hazard();
        logic [4:0] lt;
        lt = m_ins[20:16];
        return m_vld && m_ins[31:26] == 6'h23 && lt != 0 &&
               (instruction[25:21] == lt || instruction[20:16] == lt);
    endfunction

    function automatic logic m_ready();
        return !rst && (!m_vld || out_ready) && !m_hazard() && !flush;
    endfunction

    task automatic drv(input logic iv, input logic [31:0] ins, input logic ordy,
                       input logic fl, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd);
        in_valid = iv; instruction = ins; out_ready = ordy; flush = fl;
        wb_en = we; wb_reg = wr; wb_data = wd; pc_plus4 = $urandom;
    endtask

    task automatic chk_outs();
        chk("out_valid", out_valid, m_vld);
        chk("stall_count", stall_count, m_cnt);
        chk("fields", {opcode, rs, rt, rd, shamt, funct},
            {m_ins[31:26], m_ins[25:21], m_ins[20:16], m_ins[15:11], m_ins[10:6], m_ins[5:0]});
        chk("mem_read", mem_read, m_ins[31:26] == 6'h23);
        chk("read_data1", read_data1, m_rd1);
        chk("read_data2", read_data2, m_rd2);
        chk("imm_ext", imm_ext, m_imm);
        chk("pc_plus4_out", pc_plus4_out, m_pc);
    endtask

    // Inputs are set just after a rising edge; this checks in_ready, advances the
    // model by one clock, and checks the registered outputs after the edge.
    task automatic cycle();
        logic acc, haz;
        #3;
        chk("in_ready", in_ready, m_ready());
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_vld = 0; m_ins = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc = '0; m_cnt = 0;
        end else begin
            acc = in_valid && m_ready();
            haz = m_hazard();
            if (!flush && haz && out_ready && m_cnt < (1 << CW) - 1) m_cnt++;
            if (flush) m_vld = 0;
            else if (acc) begin
                m_vld = 1; m_ins = instruction; m_pc = pc_plus4;
                m_rd1 = m_read(instruction[25:21]);
                m_rd2 = m_read(instruction[20:16]);
                m_imm = m_immf(instruction);
            end else if (out_ready) m_vld = 0;
            if (wb_en && wb_reg != 0) m_regs[wb_reg] = wb_data;
        end
        @(posedge clk);
        #1;
        chk_outs();
    endtask

    localparam logic [31:0] LW_R8  = {6'h23, 5'd0, 5'd8, 16'h0004};
    localparam logic [31:0] ADD_R8 = {6'h00, 5'd8, 5'd1, 5'd2, 5'd0, 6'h20};

    initial begin
        foreach (m_regs[i]) m_regs[i] = '0;
        m_vld = 0; m_ins = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc = '0; m_cnt = 0;
        rst = 1;
        drv(1, 32'h00A53020, 1, 0, 1, 5'd3, 32'h55);
        @(posedge clk); #1;
        cycle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data", read_data1 | pc_plus4_out | imm_ext, 0);
        rst = 0;

        // write r5, then decode add r6,r5,r5
        drv(0, 32'h0, 1, 0, 1, 5'd5, 32'h0000_1234); cycle();
        drv(1, 32'h00A53020, 1, 0, 0, 5'd0, 32'h0); cycle();
        chk("add_rd1", read_data1, 32'h1234);
        chk("add_rd2", read_data2, 32'h1234);
        chk("add_rd_funct", {rd, funct}, {5'd6, 6'h20});

        // same-cycle write-back of r9 and r0 writes
        drv(1, {6'h00, 5'd9, 5'd0, 5'd10, 5'd0, 6'h20}, 1, 0, 1, 5'd9, 32'hDEAD_BEEF); cycle();
        chk("bypass_rd1", read_data1, 32'hDEAD_BEEF);
        drv(0, 32'h0, 1, 0, 1, 5'd0, 32'h5); cycle();
        drv(1, 32'h0000_0020, 1, 0, 1, 5'd0, 32'h7); cycle();
        chk("r0_reads_zero", read_data1, 0);

        // immediates
        drv(1, {6'h08, 5'd1, 5'd2, 16'hFFF0}, 1, 0, 0, 5'd0, 32'h0); cycle();
        chk("addi_imm", imm_ext, 32'hFFFF_FFF0);
        drv(1, {6'h0D, 5'd1, 5'd2, 16'hFFF0}, 1, 0, 0, 5'd0, 32'h0); cycle();
        chk("ori_imm", imm_ext, 32'h0000_FFF0);
        drv(1, {6'h0F, 5'd0, 5'd3, 16'h1234}, 1, 0, 0, 5'd0, 32'h0); cycle();
        chk("lui_imm", imm_ext, 32'h1234_0000);

        // load-use with execute ready: one bubble
        drv(1, LW_R8, 1, 0, 0, 5'd0, 32'h0); cycle();
        drv(1, ADD_R8, 1, 0, 0, 5'd0, 32'h0); cycle();
        chk("bubble_vld", out_valid, 0);
        chk("bubble_cnt", stall_count, 1);
        cycle();
        chk("after_bubble_vld", out_valid, 1);
        chk("after_bubble_op", {opcode, rs}, {6'h00, 5'd8});

        // load-use with execute stalled: hold, no count, then bubble
        drv(1, LW_R8, 1, 0, 0, 5'd0, 32'h0); cycle();
        drv(1, ADD_R8, 0, 0, 0, 5'd0, 32'h0); cycle(); cycle();
        chk("hold_cnt", stall_count, 1);
        chk("hold_mem_read", mem_read, 1);
        out_ready = 1; cycle(); cycle();

        // backpressure then flush
        drv(1, {6'h08, 5'd3, 5'd4, 16'h0010}, 0, 0, 0, 5'd0, 32'h0);
        cycle(); cycle(); cycle();
        flush = 1; out_ready = 0; cycle();
        chk("flush_vld", out_valid, 0);
        flush = 0; cycle();

        // reset in the middle of a held load-use stall
        drv(1, LW_R8, 1, 0, 0, 5'd0, 32'h0); cycle();
        drv(1, ADD_R8, 0, 0, 0, 5'd0, 32'h0); cycle();
        rst = 1; cycle();
        chk("rst_mid_cnt", stall_count, 0);
        chk("rst_mid_vld", out_valid, 0);
        rst = 0;
        drv(1, {6'h00, 5'd5, 5'd9, 5'd1, 5'd0, 6'h20}, 1, 0, 0, 5'd0, 32'h0); cycle();
        chk("rst_regs_zero", {read_data1, read_data2}, 0);

        // saturation
        for (int k = 0; k < 5; k++) begin
            drv(1, LW_R8, 1, 0, 0, 5'd0, 32'h0); cycle();
            drv(1, ADD_R8, 1, 0, 0, 5'd0, 32'h0); cycle(); cycle();
        end
        chk("sat_cnt", stall_count, 3);

        // randomized traffic on a small register window to provoke hazards
        rst = 1; cycle(); rst = 0;
        for (int n = 0; n < 600; n++) begin
            logic [5:0] op;
            case ($urandom_range(0, 6))
                0: op = 6'h00; 1: op = 6'h23; 2: op = 6'h08; 3: op = 6'h0C;
                4: op = 6'h0D; 5: op = 6'h0E; default: op = 6'h0F;
            endcase
            drv($urandom_range(0, 3) != 0,
                {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)},
                $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 4)), $urandom);
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parameterised ID stage: register file, immediate extender, registered ID/EX output with valid/ready handshake.
- Adds write-through bypass, load-use hazard detection with one-bubble insertion, flush, and a saturating stall counter.
- Sits between the fetch stage (IF/ID) and execute; it takes register writes from write-back.

Parameters:
DATA_W, 32, datapath width in bits; must be >= 32.
NUM_REGS, 32, register count; must be 32 (5-bit specifiers).
STALL_CNT_W, 16, width of the stall counter.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset; synchronous, active-high
in_valid  input  1  instruction presented by fetch
in_ready  output  1  stage accepts the instruction this cycle
instruction  input  32  instruction word
pc_plus4  input  DATA_W  PC+4 of the instruction
flush  input  1  kill the instruction held in the output register
wb_en  input  1  register write enable
wb_reg  input  5  write register number
wb_data  input  DATA_W  write data
out_valid  output  1  ID/EX register holds a valid instruction
out_ready  input  1  execute accepts the output this cycle
opcode  output  6  instr[31:26]
funct  output  6  instr[5:0]
shamt  output  5  instr[10:6]
rs, rt, rd  output  5 each  instr[25:21], [20:16], [15:11]
read_data1  output  DATA_W  value of rs
read_data2  output  DATA_W  value of rt
imm_ext  output  DATA_W  extended immediate
pc_plus4_out  output  DATA_W  registered PC+4
mem_read  output  1  opcode == 6'h23 (lw)
stall_count  output  STALL_CNT_W  count of load-use bubbles, saturating

Behaviour:
- Register file:
  - NUM_REGS x DATA_W; write on clk when wb_en && wb_reg != 0.
  - Register 0 always reads 0.
  - Reads are combinational with write-through: if wb_en && wb_reg == read address && address != 0, the read returns wb_data.
- Immediate extension, from instr[15:0]:
  - Opcodes 6'h0C, 6'h0D, 6'h0E: zero-extend.
  - Opcode 6'h0F (lui): imm << 16, upper bits zero.
  - All other opcodes: sign-extend to DATA_W.
- Hazard:
  - hazard = out_valid && mem_read && rt_out != 0 && (instr rs == rt_out || instr rt == rt_out).
  - Compare against the registered rt; evaluate regardless of in_valid.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard && !flush.
  - Accept when in_valid && in_ready.
  - On accept, all output registers load next cycle and out_valid <= 1.
  - If the output moves out (out_ready) with no accept, out_valid <= 0.
  - If out_valid && !out_ready, all outputs hold.
- Bubble:
  - When hazard && out_ready: out_valid <= 0, the instruction is not accepted, and stall_count increments.
  - Next cycle the hazard is clear and the instruction is accepted.
  - Penalty is exactly one cycle.
  - Hazard with !out_ready: hold only; no count.
- Flush: out_valid <= 0 next cycle; no accept that cycle; priority over accept and bubble. stall_count is unchanged by flush.
- Latency: one cycle from accept to out_valid.
- stall_count saturates at all-ones; cleared only by rst.
- Reset, when rst is high at the edge:
  - out_valid = 0; all data outputs = 0; stall_count = 0; every register = 0.
  - Reset has priority over flush, writes and accept.
  - in_ready = 0 while rst is high.
  - Reset mid-hazard or mid-stall discards the held instruction.
- Simultaneous write-back and decode of the same register: decode captures wb_data.
- Writes to register 0 are dropped.

Test Plan:
1. Reset, then wb writes r5=0x0000_1234. Decode 0x00A5_3020 (add r6,r5,r5) -> next cycle out_valid=1, read_data1=read_data2=0x1234, rd=6, funct=0x20.
2. Same cycle: wb_en r9=0xDEAD_BEEF and decode instruction with rs=r9 -> read_data1=0xDEAD_BEEF. Writing r0=5 then reading r0 -> 0.
3. Immediates:
   - addi with imm 0xFFF0 -> imm_ext=0xFFFF_FFF0.
   - ori with 0xFFF0 -> 0x0000_FFF0.
   - lui with 0x1234 -> 0x1234_0000.
4. Load-use:
   - lw r8 accepted, then add rs=r8 with out_ready=1 -> one cycle out_valid=0, in_ready=0, stall_count=1.
   - The add is accepted next cycle.
   - Repeat with out_ready=0 -> outputs hold, count unchanged.
5. Backpressure and flush:
   - out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
   - Assert flush -> out_valid=0 next cycle, no instruction accepted.
6. Assert rst mid-stall -> all outputs 0, stall_count=0, registers read 0.
   - Force stall_count to all-ones (STALL_CNT_W=2) -> count stays 3 on further bubbles.
